// File: rtl/asg_seq_pkg.sv
// Types and widths for the ASG segment sequencer.
package asg_seq_pkg;

  localparam int unsigned CWM  = 14;
  localparam int unsigned CWF  = 16;
  localparam int unsigned CTW  = CWM + CWF;
  localparam int unsigned NSEG = 8;
  localparam int unsigned AW   = $clog2(NSEG);
  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 16;
  localparam int unsigned RW1  = RW + 1;

  // Fixed-point step/offset, same format as the generator counter.
  typedef logic [int'(CWM)-1:-int'(CWF)] ct_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } seq_state_t;

  typedef struct packed {
    ct_t             ste;
    ct_t             off;
    logic [DW-1:0]   dur;
  } seg_t;

  // Index of the segment after 'seg', wrapping after the last one.
  function automatic logic [AW-1:0] seg_next(input logic [AW-1:0] seg,
                                             input logic [AW-1:0] lst);
    return (seg == lst) ? '0 : AW'(seg + AW'(1));
  endfunction

endpackage

// File: rtl/evn_pkg.sv
// Shared event bundle used between sequencer, register bank and generator.
package evn_pkg;

  typedef struct packed {
    logic rst;
    logic str;
    logic stp;
    logic swt;
  } evn_t;

endpackage

// File: rtl/asg_seq_if.sv
// Event, config and status bundle between register bank and sequencer.
interface asg_seq_if;
  import asg_seq_pkg::*;

  evn_pkg::evn_t   evn;
  evn_pkg::evn_t   evs;
  logic            ctl_trg;
  logic            ctl_rdy;
  logic            cfg_wen;
  logic [AW-1:0]   cfg_wad;
  ct_t             cfg_wst;
  ct_t             cfg_wof;
  logic [DW-1:0]   cfg_wdu;
  logic [AW-1:0]   cfg_lst;
  logic [RW-1:0]   cfg_rep;
  logic            cfg_pcn;
  evn_pkg::evn_t   asg_evn;
  ct_t             asg_ste;
  ct_t             asg_off;
  logic [AW-1:0]   sts_seg;
  logic [RW-1:0]   sts_rep;

  // Register bank / controller side.
  modport master (
    output evn, ctl_trg, ctl_rdy,
    output cfg_wen, cfg_wad, cfg_wst, cfg_wof, cfg_wdu,
    output cfg_lst, cfg_rep, cfg_pcn,
    input  evs, asg_evn, asg_ste, asg_off, sts_seg, sts_rep
  );

  // Sequencer side.
  modport slave (
    input  evn, ctl_trg, ctl_rdy,
    input  cfg_wen, cfg_wad, cfg_wst, cfg_wof, cfg_wdu,
    input  cfg_lst, cfg_rep, cfg_pcn,
    output evs, asg_evn, asg_ste, asg_off, sts_seg, sts_rep
  );

endinterface

// File: rtl/asg_seq_tbl.sv
// Segment table: register array, one-cycle write, combinational read.
module asg_seq_tbl
  import asg_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen_i,
  input  logic [AW-1:0] wad_i,
  input  seg_t          wdat_i,
  input  logic [AW-1:0] rad_i,
  output seg_t          rdat_o_c
);

  seg_t mem_q [NSEG];

  // Table storage; cleared only by the hardware reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wen_i) begin
      mem_q[wad_i] <= wdat_i;
    end
  end

  assign rdat_o_c = mem_q[rad_i];

endmodule

// File: rtl/asg_seq.sv
// Segment sequencer: steps the generator through a table of
// (step, offset, duration) segments for hopping / burst waveforms.
module asg_seq
  import asg_seq_pkg::*;
  import evn_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETn,
  asg_seq_if.slave    bus
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] seg_q, seg_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [DW-1:0] dur_q, dur_d;
  ct_t           ste_q, ste_d;
  ct_t           off_q, off_d;
  evn_t          aevn_q, aevn_d;
  evn_t          evs_q, evs_d;

  logic [AW-1:0] rd_idx;
  seg_t          rd_seg;
  seg_t          wr_seg;
  logic          trg;
  logic          last_seg;
  logic          rep_end;
  logic [RW-1:0] rep_inc;
  logic          load;
  logic          pulse;
  logic          eos;

  assign wr_seg = '{ste: bus.cfg_wst, off: bus.cfg_wof, dur: bus.cfg_wdu};

  asg_seq_tbl u_tbl (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .wen_i    (bus.cfg_wen),
    .wad_i    (bus.cfg_wad),
    .wdat_i   (wr_seg),
    .rad_i    (rd_idx),
    .rdat_o_c (rd_seg)
  );

  assign trg      = bus.evn.swt | bus.ctl_trg;
  assign last_seg = (seg_q == bus.cfg_lst);
  // Final repetition: the pass now ending brings the count to cfg_rep.
  assign rep_end  = (bus.cfg_rep != '0) &&
                    ((RW1'(rep_q) + RW1'(1)) == RW1'(bus.cfg_rep));
  assign rep_inc  = (&rep_q) ? rep_q : RW'(rep_q + RW'(1));

  // Entry to load: segment 0 when starting, otherwise the successor.
  assign rd_idx = (state_q == RUN) ? seg_next(seg_q, bus.cfg_lst) : '0;

  // Next-state, counters and event pulses.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    rep_d   = rep_q;
    dur_d   = dur_q;
    ste_d   = ste_q;
    off_d   = off_q;
    load    = 1'b0;
    pulse   = 1'b0;
    eos     = 1'b0;

    if (bus.evn.rst) begin
      state_d = IDLE;
      seg_d   = '0;
      rep_d   = '0;
      dur_d   = '0;
      ste_d   = '0;
      off_d   = '0;
    end else if (bus.evn.stp) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.evn.str) begin
            if (trg) begin
              state_d = RUN;
              load    = 1'b1;
              pulse   = 1'b1;
              rep_d   = '0;
            end else begin
              state_d = ARMED;
            end
          end
        end
        ARMED: begin
          if (trg) begin
            state_d = RUN;
            load    = 1'b1;
            pulse   = 1'b1;
            rep_d   = '0;
          end
        end
        RUN: begin
          if (bus.ctl_rdy) begin
            if (dur_q != '0) begin
              dur_d = dur_q - DW'(1);
            end else if (last_seg && rep_end) begin
              eos     = 1'b1;
              rep_d   = rep_inc;
              state_d = IDLE;
            end else begin
              load  = 1'b1;
              pulse = ~bus.cfg_pcn;
              if (last_seg) begin
                rep_d = rep_inc;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        seg_d = rd_idx;
        dur_d = rd_seg.dur;
        ste_d = rd_seg.ste;
        off_d = rd_seg.off;
      end
    end

    aevn_d = '{rst: bus.evn.rst, str: bus.evn.str,
               stp: bus.evn.stp | eos, swt: pulse};
    evs_d  = '{rst: 1'b0, str: (state_d != IDLE),
               stp: (state_d == IDLE), swt: (state_d == RUN)};
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      seg_q   <= '0;
      rep_q   <= '0;
      dur_q   <= '0;
      ste_q   <= '0;
      off_q   <= '0;
      aevn_q  <= '0;
      evs_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      rep_q   <= rep_d;
      dur_q   <= dur_d;
      ste_q   <= ste_d;
      off_q   <= off_d;
      aevn_q  <= aevn_d;
      evs_q   <= evs_d;
    end
  end

  assign bus.asg_evn = aevn_q;
  assign bus.evs     = evs_q;
  assign bus.asg_ste = ste_q;
  assign bus.asg_off = off_q;
  assign bus.sts_seg = seg_q;
  assign bus.sts_rep = rep_q;

endmodule
